// File: rtl/regfile_loader_pkg.sv
// Shared types and constants for the double-banked register file write-side loader.
// Optional stall counter is enabled with REGFILE_LOADER_STALL_CNT_EN.
package regfile_loader_pkg;

    typedef enum logic [1:0] {
        S_LO    = 2'd0,
        S_HI    = 2'd1,
        S_STALL = 2'd2
    } state_e;

    typedef logic bank_id_t;

    localparam int STALL_CNT_W = 16;

    function automatic int blocks_per_bank(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/regfile_bank_tracker.sv
// Bank ownership flags and per-bank block counts; arbitrates a commit from the loader
// against a release from the reader landing on the same edge.
module regfile_bank_tracker
    import regfile_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  commit_valid,
    input  bank_id_t              commit_bank,
    input  logic [ADDR_WIDTH-1:0] commit_count,
    input  logic                  release_valid,
    input  bank_id_t              release_bank,
    output logic [1:0]            bank_full,
    output logic [ADDR_WIDTH-1:0] bank_count0,
    output logic [ADDR_WIDTH-1:0] bank_count1
);

    logic [1:0]            full_q, full_d;
    logic [ADDR_WIDTH-1:0] count0_q, count0_d;
    logic [ADDR_WIDTH-1:0] count1_q, count1_d;

    // Release is applied first so that a commit to the same bank overrides it.
    always_comb begin
        full_d   = full_q;
        count0_d = count0_q;
        count1_d = count1_q;
        if (release_valid && full_q[release_bank]) begin
            full_d[release_bank] = 1'b0;
        end
        if (commit_valid) begin
            full_d[commit_bank] = 1'b1;
            if (commit_bank) begin
                count1_d = commit_count;
            end else begin
                count0_d = commit_count;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full_q   <= '0;
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            full_q   <= full_d;
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign bank_full   = full_q;
    assign bank_count0 = count0_q;
    assign bank_count1 = count1_q;

endmodule

// File: rtl/regfile_bank_loader.sv
// Packs a valid/ready word stream into two-word blocks, drives the register file write port
// and ping-pongs banks. Define REGFILE_LOADER_STALL_CNT_EN to add the stallCount output.
module regfile_bank_loader
    import regfile_loader_pkg::*;
#(
    parameter int PORT_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [PORT_WIDTH-1:0]  inData,
    input  logic                   inValid,
    input  logic                   inLast,
    output logic                   inReady,
    output logic                   writeEnable,
    output logic                   writeBank,
    output logic [ADDR_WIDTH-2:0]  writeAddrTransferBlock,
    output logic [PORT_WIDTH-1:0]  writeData0,
    output logic [PORT_WIDTH-1:0]  writeData1,
    output logic [1:0]             bankFull,
    output logic [ADDR_WIDTH-1:0]  bankCount0,
    output logic [ADDR_WIDTH-1:0]  bankCount1,
    input  logic                   bankRelease,
    input  logic                   bankReleaseId,
`ifdef REGFILE_LOADER_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stallCount,
`endif
    output state_e                 dbgState
);

    localparam int IW  = ADDR_WIDTH - 1;
    localparam int BPB = blocks_per_bank(ADDR_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(BPB - 1);

    // Stream handshake: a word moves when inValid and inReady are both high at a rising edge;
    // inReady depends only on registered state, never on inValid.
    state_e                state_q, state_d;
    bank_id_t              fill_bank_q, fill_bank_d;
    logic [IW-1:0]         blk_idx_q, blk_idx_d;
    logic [PORT_WIDTH-1:0] data0_q, data0_d;
    logic                  we_q, we_d;
    bank_id_t              wbank_q, wbank_d;
    logic [IW-1:0]         waddr_q, waddr_d;
    logic [PORT_WIDTH-1:0] wdata0_q, wdata0_d;
    logic [PORT_WIDTH-1:0] wdata1_q, wdata1_d;
    logic                  commit_q, commit_d;

    logic                  accept;
    logic                  do_strobe;
    logic [PORT_WIDTH-1:0] pair_lo, pair_hi;
    logic [1:0]            bank_full;
    logic [ADDR_WIDTH-1:0] commit_count;

    assign inReady = resetn & (state_q != S_STALL) & ~bank_full[fill_bank_q];
    assign accept  = inValid & inReady;

    always_comb begin
        state_d     = state_q;
        fill_bank_d = fill_bank_q;
        blk_idx_d   = blk_idx_q;
        data0_d     = data0_q;
        we_d        = 1'b0;
        wbank_d     = wbank_q;
        waddr_d     = waddr_q;
        wdata0_d    = wdata0_q;
        wdata1_d    = wdata1_q;
        commit_d    = 1'b0;
        do_strobe   = 1'b0;
        pair_lo     = data0_q;
        pair_hi     = '0;
        case (state_q)
            S_LO: begin
                if (accept) begin
                    data0_d = inData;
                    if (inLast) begin
                        do_strobe = 1'b1;
                        pair_lo   = inData;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    do_strobe = 1'b1;
                    pair_hi   = inData;
                    state_d   = S_LO;
                end
            end
            S_STALL: begin
                if (!bank_full[fill_bank_q]) begin
                    state_d = S_LO;
                end
            end
            default: state_d = S_LO;
        endcase

        // The bank flag itself is raised one cycle later, after the write port has the data.
        if (do_strobe) begin
            we_d     = 1'b1;
            wbank_d  = fill_bank_q;
            waddr_d  = blk_idx_q;
            wdata0_d = pair_lo;
            wdata1_d = pair_hi;
            commit_d = inLast | (blk_idx_q == LAST_IDX);
            if (commit_d) begin
                blk_idx_d   = '0;
                fill_bank_d = ~fill_bank_q;
                if (bank_full[~fill_bank_q]) begin
                    state_d = S_STALL;
                end
            end else begin
                blk_idx_d = blk_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_LO;
            fill_bank_q <= 1'b0;
            blk_idx_q   <= '0;
            data0_q     <= '0;
            we_q        <= 1'b0;
            wbank_q     <= 1'b0;
            waddr_q     <= '0;
            wdata0_q    <= '0;
            wdata1_q    <= '0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_bank_q <= fill_bank_d;
            blk_idx_q   <= blk_idx_d;
            data0_q     <= data0_d;
            we_q        <= we_d;
            wbank_q     <= wbank_d;
            waddr_q     <= waddr_d;
            wdata0_q    <= wdata0_d;
            wdata1_q    <= wdata1_d;
            commit_q    <= commit_d;
        end
    end

    assign commit_count = {1'b0, waddr_q} + ADDR_WIDTH'(1);

    regfile_bank_tracker #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_tracker (
        .clock        (clock),
        .resetn       (resetn),
        .commit_valid (commit_q),
        .commit_bank  (wbank_q),
        .commit_count (commit_count),
        .release_valid(bankRelease),
        .release_bank (bankReleaseId),
        .bank_full    (bank_full),
        .bank_count0  (bankCount0),
        .bank_count1  (bankCount1)
    );

`ifdef REGFILE_LOADER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (inValid && !inReady && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
`endif

    assign writeEnable            = we_q;
    assign writeBank              = wbank_q;
    assign writeAddrTransferBlock = waddr_q;
    assign writeData0             = wdata0_q;
    assign writeData1             = wdata1_q;
    assign bankFull               = bank_full;
    assign dbgState               = state_q;

endmodule

// File: tb/tb_regfile_bank_loader.sv
// Bench for regfile_bank_loader: table-driven stream test, directed corner sequences and a
// randomized run against a word-list reference model. Honors REGFILE_LOADER_STALL_CNT_EN.
module tb_regfile_bank_loader;
    import regfile_loader_pkg::*;

    localparam int PW  = 16;
    localparam int AW  = 4;
    localparam int BPB = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [PW-1:0] inData = '0;
    logic          inValid = 1'b0;
    logic          inLast = 1'b0;
    logic          inReady;
    logic          writeEnable;
    logic          writeBank;
    logic [AW-2:0] writeAddrTransferBlock;
    logic [PW-1:0] writeData0, writeData1;
    logic [1:0]    bankFull;
    logic [AW-1:0] bankCount0, bankCount1;
    logic          bankRelease = 1'b0;
    logic          bankReleaseId = 1'b0;
    state_e        dbgState;
`ifdef REGFILE_LOADER_STALL_CNT_EN
    logic [15:0]   stallCount;
`endif

    regfile_bank_loader #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clock                 (clock),
        .resetn                (resetn),
        .inData                (inData),
        .inValid               (inValid),
        .inLast                (inLast),
        .inReady               (inReady),
        .writeEnable           (writeEnable),
        .writeBank             (writeBank),
        .writeAddrTransferBlock(writeAddrTransferBlock),
        .writeData0            (writeData0),
        .writeData1            (writeData1),
        .bankFull              (bankFull),
        .bankCount0            (bankCount0),
        .bankCount1            (bankCount1),
        .bankRelease           (bankRelease),
        .bankReleaseId         (bankReleaseId),
`ifdef REGFILE_LOADER_STALL_CNT_EN
        .stallCount            (stallCount),
`endif
        .dbgState              (dbgState)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    // Words of the current block are kept in a list; each bank is a simple flag + count.
    typedef struct {
        logic          bank;
        int            idx;
        logic [PW-1:0] d1;
        logic [PW-1:0] d0;
    } wr_t;

    logic [PW-1:0] m_pair[$];
    logic [1:0]    m_full;
    int            m_cnt[2];
    logic          m_fb;
    int            m_idx;
    bit            m_stall;
    bit            m_pend;
    logic          m_pend_b;
    int            m_pend_n;
    bit            m_we;
    wr_t           m_wr;
    int            m_stall_cnt;

    function automatic bit m_ready();
        return !m_stall && !m_full[m_fb];
    endfunction

    function automatic void model_reset();
        m_pair.delete();
        m_full = 2'b00;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_fb = 1'b0;
        m_idx = 0;
        m_stall = 0;
        m_pend = 0;
        m_pend_b = 1'b0;
        m_pend_n = 0;
        m_we = 0;
        m_wr = '{bank: 1'b0, idx: 0, d1: '0, d0: '0};
        m_stall_cnt = 0;
    endfunction

    // Advances the model over one rising edge given the inputs held during the preceding cycle.
    function automatic void model_edge(input bit v, input logic [PW-1:0] d, input bit l,
                                       input bit rel, input logic rid);
        logic [1:0] old_full = m_full;
        bit acc = v && m_ready();
        if (v && !m_ready() && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
        if (rel && old_full[rid]) m_full[rid] = 1'b0;
        if (m_pend) begin
            m_full[m_pend_b] = 1'b1;
            m_cnt[m_pend_b]  = m_pend_n;
        end
        m_pend = 0;
        m_we   = 0;
        if (m_stall && !old_full[m_fb]) m_stall = 0;
        if (acc) begin
            m_pair.push_back(d);
            if (m_pair.size() == 2 || l) begin
                m_we      = 1;
                m_wr.bank = m_fb;
                m_wr.idx  = m_idx;
                m_wr.d0   = m_pair[0];
                m_wr.d1   = (m_pair.size() == 2) ? m_pair[1] : '0;
                m_pair.delete();
                m_idx++;
                if (l || m_idx == BPB) begin
                    m_pend   = 1;
                    m_pend_b = m_fb;
                    m_pend_n = m_idx;
                    m_idx    = 0;
                    if (old_full[!m_fb]) m_stall = 1;
                    m_fb = !m_fb;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        chk("writeEnable", 32'(writeEnable), 32'(m_we));
        if (m_we) begin
            chk("writeBank", 32'(writeBank), 32'(m_wr.bank));
            chk("writeAddr", 32'(writeAddrTransferBlock), 32'(m_wr.idx));
            chk("writeData0", 32'(writeData0), 32'(m_wr.d0));
            chk("writeData1", 32'(writeData1), 32'(m_wr.d1));
        end
        chk("bankFull", 32'(bankFull), 32'(m_full));
        chk("bankCount0", 32'(bankCount0), 32'(m_cnt[0]));
        chk("bankCount1", 32'(bankCount1), 32'(m_cnt[1]));
        chk("inReady", 32'(inReady), 32'(m_ready()));
`ifdef REGFILE_LOADER_STALL_CNT_EN
        chk("stallCount", 32'(stallCount), 32'(m_stall_cnt));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive, step model, let one rising edge pass, check at next fall.
    task automatic step(input bit v, input logic [PW-1:0] d, input bit l,
                        input bit rel, input logic rid);
        inValid       = v;
        inData        = d;
        inLast        = l;
        bankRelease   = rel;
        bankReleaseId = rid;
        model_edge(v, d, l, rel, rid);
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        inValid       = 1'b0;
        inData        = '0;
        inLast        = 1'b0;
        bankRelease   = 1'b0;
        bankReleaseId = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        check_outputs();
        chk("reset_state", 32'(dbgState), 32'(S_LO));
        chk("reset_wdata", 32'({writeData1, writeData0}), 32'd0);
    endtask

    task automatic fill_bank(input logic [PW-1:0] base);
        for (int i = 0; i < 2 * BPB; i++) step(1, base + PW'(i), 0, 0, 1'b0);
    endtask

    // ---------------- table-driven stream test ----------------
    typedef struct {
        bit            v;
        logic [PW-1:0] d;
        bit            we;
        logic          bank;
        int            idx;
        logic [PW-1:0] d1;
        logic [PW-1:0] d0;
        logic [1:0]    full;
        int            cnt0;
    } vec_t;

    vec_t vecs[19];

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{v: 1, d: PW'(i + 1), we: (i % 2 == 1), bank: 1'b0, idx: i / 2,
                        d1: PW'(i + 1), d0: PW'(i), full: 2'b00, cnt0: 0};
        end
        vecs[16] = '{v: 0, d: '0,       we: 0, bank: 1'b0, idx: 0, d1: '0,       d0: '0,       full: 2'b01, cnt0: 8};
        vecs[17] = '{v: 1, d: 16'h0011, we: 0, bank: 1'b0, idx: 0, d1: '0,       d0: '0,       full: 2'b01, cnt0: 8};
        vecs[18] = '{v: 1, d: 16'h0012, we: 1, bank: 1'b1, idx: 0, d1: 16'h0012, d0: 16'h0011, full: 2'b01, cnt0: 8};

        @(negedge clock);
        do_reset();

        for (int r = 0; r < 19; r++) begin
            step(vecs[r].v, vecs[r].d, 0, 0, 1'b0);
            chk($sformatf("tbl%0d_we", r), 32'(writeEnable), 32'(vecs[r].we));
            if (vecs[r].we) begin
                chk($sformatf("tbl%0d_bank", r), 32'(writeBank), 32'(vecs[r].bank));
                chk($sformatf("tbl%0d_idx", r), 32'(writeAddrTransferBlock), 32'(vecs[r].idx));
                chk($sformatf("tbl%0d_data", r), {writeData1, writeData0}, {vecs[r].d1, vecs[r].d0});
            end
            chk($sformatf("tbl%0d_full", r), 32'(bankFull), 32'(vecs[r].full));
            chk($sformatf("tbl%0d_cnt0", r), 32'(bankCount0), 32'(vecs[r].cnt0));
        end

        // Five words closed by inLast: partial last block, count 3.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1, PW'(i), (i == 5), 0, 1'b0);
        chk("last5_idx", 32'(writeAddrTransferBlock), 32'd2);
        chk("last5_data", {writeData1, writeData0}, 32'h0000_0005);
        idle(1);
        chk("last5_full", 32'(bankFull), 32'b01);
        chk("last5_cnt0", 32'(bankCount0), 32'd3);

        // Single inLast word into an empty bank.
        do_reset();
        step(1, 16'hBEEF, 1, 0, 1'b0);
        chk("single_data", {writeData1, writeData0}, 32'h0000_BEEF);
        idle(1);
        chk("single_cnt0", 32'(bankCount0), 32'd1);

        // Both banks filled, then release bank 0 out of the stall.
        do_reset();
        fill_bank(16'h0100);
        fill_bank(16'h0200);
        chk("stall_state", 32'(dbgState), 32'(S_STALL));
        chk("stall_ready", 32'(inReady), 32'd0);
        step(1, 16'h0300, 0, 0, 1'b0);
        chk("stall_full", 32'(bankFull), 32'b11);
        for (int i = 0; i < 9; i++) step(1, 16'h0300, 0, 0, 1'b0);
`ifdef REGFILE_LOADER_STALL_CNT_EN
        chk("stall_count10", 32'(stallCount), 32'd10);
`endif
        step(1, 16'h0300, 0, 1, 1'b0);
        chk("rel0_full", 32'(bankFull), 32'b10);
        chk("rel0_ready_held", 32'(inReady), 32'd0);
        step(1, 16'h0300, 0, 0, 1'b0);
        chk("rel0_ready", 32'(inReady), 32'd1);
        step(1, 16'h0300, 0, 0, 1'b0);
        step(1, 16'h0301, 0, 0, 1'b0);
        chk("resume_bank", 32'(writeBank), 32'd0);
        chk("resume_idx", 32'(writeAddrTransferBlock), 32'd0);
        chk("resume_data", {writeData1, writeData0}, 32'h0301_0300);

        // Commit of bank 1 on the same edge as release of bank 0; early release of bank 1 ignored.
        do_reset();
        step(1, 16'h0A01, 1, 0, 1'b0);
        idle(1);
        chk("atom_full0", 32'(bankFull), 32'b01);
        step(1, 16'h0B01, 0, 1, 1'b1);
        chk("ign_rel1", 32'(bankFull), 32'b01);
        step(1, 16'h0B02, 1, 0, 1'b0);
        chk("atom_bank1", 32'(writeBank), 32'd1);
        step(0, '0, 0, 1, 1'b0);
        chk("atom_swap", 32'(bankFull), 32'b10);
        chk("atom_cnt1", 32'(bankCount1), 32'd1);

        // Asynchronous reset with a strobe on the write port and a word held.
        do_reset();
        step(1, 16'h0001, 0, 0, 1'b0);
        step(1, 16'h0002, 0, 0, 1'b0);
        inValid = 1'b1;
        inData  = 16'h0003;
        @(posedge clock);
        step_async_reset();
        do_reset();
        step(1, 16'h00A1, 0, 0, 1'b0);
        step(1, 16'h00A2, 0, 0, 1'b0);
        chk("rst_restart_idx", 32'(writeAddrTransferBlock), 32'd0);
        chk("rst_restart_data", {writeData1, writeData0}, 32'h00A2_00A1);

        // Randomized traffic with a random reader.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit            v   = ($urandom_range(0, 3) != 0);
            logic [PW-1:0] d   = PW'($urandom);
            bit            l   = ($urandom_range(0, 9) == 0);
            bit            rel = ($urandom_range(0, 4) == 0);
            logic          rid = 1'($urandom_range(0, 1));
            if (rel && m_full != 2'b00 && $urandom_range(0, 3) != 0) begin
                rid = (m_full == 2'b11) ? 1'($urandom_range(0, 1)) : m_full[1];
            end
            step(v, d, l, rel, rid);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic step_async_reset();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_we", 32'(writeEnable), 32'd0);
        chk("arst_wdata", {writeData1, writeData0}, 32'd0);
        chk("arst_full", 32'(bankFull), 32'd0);
        chk("arst_ready", 32'(inReady), 32'd0);
        chk("arst_state", 32'(dbgState), 32'(S_LO));
        @(negedge clock);
    endtask

endmodule
